// File: rtl/uart_pkg.sv
// Shared UART definitions for the console link (receive and transmit paths).
// Contents:
//   uart_state_e        - receiver frame FSM states
//   UART_DATA_BITS      - payload bits per 8N1 frame
//   UART_RATE_FREQ_BAUD - default sys_clk cycles per bit (10 MHz / 115200)
package uart_pkg;

  localparam int UART_DATA_BITS      = 8;
  localparam int UART_RATE_FREQ_BAUD = 87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO for UART bytes; usable on either the RX or TX side.
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   push_i   - write wdata_i; ignored when full unless a pop happens in the same cycle
//   wdata_i  - byte to write
//   pop_i    - remove head; ignored when empty
//   full_o   - no free entry
//   empty_o  - no entry held
//   head_o   - current head; holds the last head value while empty
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = UART_DATA_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] last_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push_i && (!full_o || do_pop);

  // last_q tracks the head while non-empty so the output holds once drained.
  assign head_o = empty_o ? last_q : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      if (!empty_o) last_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver for the console link, sys_clk domain.
// Ports:
//   clk       - sys_clk, rising edge
//   rst       - asynchronous active-low reset
//   rx        - asynchronous serial input, idle high
//   rd        - pop the FIFO head; honoured only while data_av=1
//   data_out  - FIFO head byte (show-ahead)
//   data_av   - FIFO not empty
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   overrun   - one-cycle pulse when a byte is dropped on a full FIFO
module uart_rx
  import uart_pkg::*;
#(
  parameter int RATE_FREQ_BAUD = UART_RATE_FREQ_BAUD,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      rd,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_av,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int                CNT_W    = $clog2(RATE_FREQ_BAUD);
  localparam logic [CNT_W-1:0]  HALF_M1  = CNT_W'((RATE_FREQ_BAUD >> 1) - 1);
  localparam logic [CNT_W-1:0]  BIT_M1   = CNT_W'(RATE_FREQ_BAUD - 1);
  localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s1_q;
  logic                      rx_s2_q;
  uart_state_e               state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      frame_err_q;
  logic                      overrun_q;
  logic                      stop_sample;
  logic                      push;
  logic                      fifo_full;
  logic                      fifo_empty;

  // The stop bit is judged in the cycle the counter reaches its last value;
  // a good stop bit pushes straight into the FIFO on that edge.
  assign stop_sample = (state_q == STOP) && (cnt_q == BIT_M1);
  assign push        = stop_sample && rx_s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      frame_err_q <= 1'b0;
      // Full implies data_av, so rd is honoured whenever this matters.
      overrun_q   <= push && fifo_full && !rd;
      case (state_q)
        IDLE: begin
          if (!rx_s2_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          // Mid start bit: a high here was a glitch and is dropped silently.
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (!rx_s2_q) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[UART_DATA_BITS-1:1]};
            if (bit_idx_q == LAST_BIT) state_q <= STOP;
            else                       bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop lets the next start edge arrive with no idle gap.
          if (cnt_q == BIT_M1) begin
            cnt_q       <= '0;
            frame_err_q <= !rx_s2_q;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (rd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (data_out)
  );

  assign data_av   = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
